// File: rtl/l2_arbiter_pkg.sv
// ============================================================================
// Module  : l2_arbiter_pkg
// Brief   : Shared L2 types for the I/D line-port arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

package l2_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int LINE_W = 256;

    localparam logic [3:0] LINE_MASK = 4'hF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } l2_arb_state_t;

    typedef enum logic {
        OP_READ  = 1'b0,
        OP_WRITE = 1'b1
    } l2_arb_op_t;

    typedef enum logic {
        OWN_I = 1'b0,
        OWN_D = 1'b1
    } l2_arb_owner_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        l2_arb_op_t        op;
        logic [LINE_W-1:0] wdata;
        l2_arb_owner_t     owner;
    } l2_arb_req_t;

    function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
        return addr & ~32'h0000_001F;
    endfunction

endpackage

`default_nettype wire

// File: rtl/l2_arbiter_rr_arb2.sv
// ============================================================================
// Module  : rr_arb2
// Brief   : Two-requester round-robin arbiter; ties go to the port not granted last.
// Revision: 1.0
// ============================================================================
`default_nettype none

module rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req_i,
    input  logic       advance_i,
    output logic [1:0] gnt_o
);

    // Index of the most recent grant; reset to 0 so the first tie goes to index 1.
    logic last_q;

    always_comb begin
        gnt_o = 2'b00;
        case (req_i)
            2'b01:   gnt_o = 2'b01;
            2'b10:   gnt_o = 2'b10;
            2'b11:   gnt_o = last_q ? 2'b01 : 2'b10;
            default: gnt_o = 2'b00;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_q <= 1'b0;
        end else if (advance_i && (gnt_o != 2'b00)) begin
            last_q <= gnt_o[1];
        end
    end

endmodule

`default_nettype wire

// File: rtl/l2_arbiter.sv
// ============================================================================
// Module  : l2_arbiter
// Brief   : Shares the L2 line port between I-cache and D-cache miss ports.
// Revision: 1.0
// ============================================================================
`default_nettype none

module l2_arbiter
    import l2_arbiter_pkg::*;
#(
    parameter int CNT_W = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [31:0]       i_addr,
    input  logic              i_read,
    output logic [255:0]      i_rdata,
    output logic              i_resp,
    input  logic [31:0]       d_addr,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [255:0]      d_wdata,
    output logic [255:0]      d_rdata,
    output logic              d_resp,
    output logic [31:0]       l2_addr,
    output logic [3:0]        l2_rmask,
    output logic [3:0]        l2_wmask,
    output logic [255:0]      l2_wdata,
    input  logic [255:0]      l2_rdata,
    input  logic              l2_resp,
    output logic [CNT_W-1:0]  i_grant_cnt,
    output logic [CNT_W-1:0]  d_grant_cnt,
    output logic [CNT_W-1:0]  i_wait_cnt,
    output logic [CNT_W-1:0]  d_wait_cnt
);

    localparam logic [CNT_W-1:0] c_cnt_one = {{(CNT_W-1){1'b0}}, 1'b1};

    l2_arb_state_t state_q, state_d;
    l2_arb_req_t   req_q, req_d;

    logic [CNT_W-1:0] i_grant_q, d_grant_q, i_wait_q, d_wait_q;

    logic       w_i_req, w_d_req, w_idle, w_grant, w_busy;
    logic [1:0] w_gnt;
    logic       w_i_owner, w_d_owner;

    assign w_i_req = i_read;
    assign w_d_req = d_read | d_write;
    assign w_idle  = (state_q == IDLE);
    assign w_busy  = (state_q == ISSUE) || (state_q == WAIT);
    assign w_grant = w_idle && (w_i_req || w_d_req);

    rr_arb2 u_rr (
        .clk       (clk),
        .rst       (rst),
        .req_i     ({w_d_req, w_i_req}),
        .advance_i (w_grant),
        .gnt_o     (w_gnt)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A response during ISSUE closes the transaction just like one in WAIT.
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (w_grant) state_d = ISSUE;
            ISSUE:   state_d = l2_resp ? IDLE : WAIT;
            WAIT:    if (l2_resp) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        l2_rmask = 4'h0;
        l2_wmask = 4'h0;
        i_resp   = 1'b0;
        d_resp   = 1'b0;
        i_rdata  = '0;
        d_rdata  = '0;
        if (state_q == ISSUE) begin
            if (req_q.op == OP_WRITE) l2_wmask = LINE_MASK;
            else                      l2_rmask = LINE_MASK;
        end
        if (w_busy && l2_resp) begin
            if (req_q.owner == OWN_I) begin
                i_resp = 1'b1;
                if (req_q.op == OP_READ) i_rdata = l2_rdata;
            end else begin
                d_resp = 1'b1;
                if (req_q.op == OP_READ) d_rdata = l2_rdata;
            end
        end
    end

    always_comb begin
        req_d       = req_q;
        req_d.owner = w_gnt[1] ? OWN_D : OWN_I;
        req_d.addr  = line_align(w_gnt[1] ? d_addr : i_addr);
        req_d.op    = (w_gnt[1] && d_write) ? OP_WRITE : OP_READ;
        req_d.wdata = w_gnt[1] ? d_wdata : '0;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            req_q <= '0;
        end else if (w_grant) begin
            req_q <= req_d;
        end
    end

    assign l2_addr  = req_q.addr;
    assign l2_wdata = req_q.wdata;

    // In IDLE the port being granted this cycle counts as owner, not as waiting.
    assign w_i_owner = w_idle ? w_gnt[0] : (req_q.owner == OWN_I);
    assign w_d_owner = w_idle ? w_gnt[1] : (req_q.owner == OWN_D);

    always_ff @(posedge clk) begin
        if (rst) begin
            i_grant_q <= '0;
            d_grant_q <= '0;
            i_wait_q  <= '0;
            d_wait_q  <= '0;
        end else begin
            if (w_grant && w_gnt[0]) i_grant_q <= i_grant_q + c_cnt_one;
            if (w_grant && w_gnt[1]) d_grant_q <= d_grant_q + c_cnt_one;
            if (w_i_req && !w_i_owner) i_wait_q <= i_wait_q + c_cnt_one;
            if (w_d_req && !w_d_owner) d_wait_q <= d_wait_q + c_cnt_one;
        end
    end

    assign i_grant_cnt = i_grant_q;
    assign d_grant_cnt = d_grant_q;
    assign i_wait_cnt  = i_wait_q;
    assign d_wait_cnt  = d_wait_q;

endmodule

`default_nettype wire

// File: tb/tb_l2_arbiter.sv
// ============================================================================
// Module  : tb_l2_arbiter
// Brief   : Directed vector bench for l2_arbiter.
// Revision: 1.0
// ============================================================================
`default_nettype none

module tb_l2_arbiter;

    logic         clk = 1'b0;
    logic         rst;
    logic [31:0]  i_addr, d_addr;
    logic         i_read, d_read, d_write, l2_resp;
    logic [255:0] d_wdata, l2_rdata;
    logic [255:0] i_rdata, d_rdata, l2_wdata;
    logic         i_resp, d_resp;
    logic [31:0]  l2_addr;
    logic [3:0]   l2_rmask, l2_wmask;
    logic [31:0]  i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt;

    localparam logic [255:0] c_rd = {32{8'hA5}};
    localparam logic [255:0] c_wd = {8{32'hDEADBEEF}};

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    l2_arbiter #(.CNT_W(32)) dut (
        .clk(clk), .rst(rst),
        .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .l2_addr(l2_addr), .l2_rmask(l2_rmask), .l2_wmask(l2_wmask),
        .l2_wdata(l2_wdata), .l2_rdata(l2_rdata), .l2_resp(l2_resp),
        .i_grant_cnt(i_grant_cnt), .d_grant_cnt(d_grant_cnt),
        .i_wait_cnt(i_wait_cnt), .d_wait_cnt(d_wait_cnt)
    );

    typedef struct {
        logic [4:0]  ctl;   // {rst, i_read, d_read, d_write, l2_resp}
        logic [31:0] ia, da;
        logic [3:0]  rm, wm;
        logic [31:0] la;
        logic [4:0]  ex;    // {i_resp, d_resp, i_rdata=A5, d_rdata=A5, l2_wdata=DEAD checked}
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] ctl, input logic [31:0] ia, input logic [31:0] da,
                       input logic [3:0] rm, input logic [3:0] wm, input logic [31:0] la,
                       input logic [4:0] ex);
        vec_t v;
        v.ctl = ctl; v.ia = ia; v.da = da; v.rm = rm; v.wm = wm; v.la = la; v.ex = ex;
        vecs.push_back(v);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; i_addr = '0; d_addr = '0; i_read = 1'b0; d_read = 1'b0;
        d_write = 1'b0; l2_resp = 1'b0; d_wdata = c_wd; l2_rdata = c_rd;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        #1;
        chk("reset l2_addr",  256'(l2_addr), 256'd0);
        chk("reset l2_wdata", l2_wdata, 256'd0);
        chk("reset masks",    256'({l2_rmask, l2_wmask}), 256'd0);
        chk("reset resp",     256'({i_resp, d_resp}), 256'd0);
        chk("reset counters", 256'({i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt}), 256'd0);

        // I read hit, D writeback, D read+write conflict, reset, tie sequence, resp in ISSUE
        add(5'b01000, 32'h1234, 32'h0, 4'h0, 4'h0, 32'h0,        5'b00000);
        add(5'b01000, 32'h1234, 32'h0, 4'hF, 4'h0, 32'h1220,     5'b00000);
        add(5'b01001, 32'h1234, 32'h0, 4'h0, 4'h0, 32'h1220,     5'b10100);
        add(5'b00000, 32'h0,    32'h0, 4'h0, 4'h0, 32'h1220,     5'b00000);
        add(5'b00010, 32'h0, 32'h8000_0040, 4'h0, 4'h0, 32'h1220,       5'b00000);
        add(5'b00010, 32'h0, 32'h8000_0040, 4'h0, 4'hF, 32'h8000_0040,  5'b00001);
        add(5'b00011, 32'h0, 32'h8000_0040, 4'h0, 4'h0, 32'h8000_0040,  5'b01001);
        add(5'b00000, 32'h0, 32'h0,         4'h0, 4'h0, 32'h8000_0040,  5'b00000);
        add(5'b00110, 32'h0, 32'h0000_0085, 4'h0, 4'h0, 32'h8000_0040,  5'b00000);
        add(5'b00110, 32'h0, 32'h0000_0085, 4'h0, 4'hF, 32'h80,         5'b00001);
        add(5'b00111, 32'h0, 32'h0000_0085, 4'h0, 4'h0, 32'h80,         5'b01000);
        add(5'b00000, 32'h0, 32'h0,         4'h0, 4'h0, 32'h80,         5'b00000);
        add(5'b10000, 32'h0, 32'h0,         4'h0, 4'h0, 32'h80,         5'b00000);
        for (int k = 0; k < 2; k++) begin
            add(5'b01100, 32'h1000, 32'h2000, 4'h0, 4'h0, (k == 0) ? 32'h0 : 32'h1000, 5'b00000);
            add(5'b01100, 32'h1000, 32'h2000, 4'hF, 4'h0, 32'h2000, 5'b00000);
            add(5'b01101, 32'h1000, 32'h2000, 4'h0, 4'h0, 32'h2000, 5'b01010);
            add(5'b01100, 32'h1000, 32'h2000, 4'h0, 4'h0, 32'h2000, 5'b00000);
            add(5'b01100, 32'h1000, 32'h2000, 4'hF, 4'h0, 32'h1000, 5'b00000);
            add(5'b01101, 32'h1000, 32'h2000, 4'h0, 4'h0, 32'h1000, 5'b10100);
        end
        add(5'b01000, 32'h3000, 32'h0, 4'h0, 4'h0, 32'h1000, 5'b00000);
        add(5'b01001, 32'h3000, 32'h0, 4'hF, 4'h0, 32'h3000, 5'b10100);
        add(5'b00000, 32'h0,    32'h0, 4'h0, 4'h0, 32'h3000, 5'b00000);
        add(5'b00000, 32'h0,    32'h0, 4'h0, 4'h0, 32'h3000, 5'b00000);

        for (int i = 0; i < vecs.size(); i++) begin
            {rst, i_read, d_read, d_write, l2_resp} = vecs[i].ctl;
            i_addr = vecs[i].ia;
            d_addr = vecs[i].da;
            #1;
            chk($sformatf("row%0d l2_rmask", i), 256'(l2_rmask), 256'(vecs[i].rm));
            chk($sformatf("row%0d l2_wmask", i), 256'(l2_wmask), 256'(vecs[i].wm));
            chk($sformatf("row%0d l2_addr", i),  256'(l2_addr),  256'(vecs[i].la));
            chk($sformatf("row%0d i_resp", i),   256'(i_resp),   256'(vecs[i].ex[4]));
            chk($sformatf("row%0d d_resp", i),   256'(d_resp),   256'(vecs[i].ex[3]));
            chk($sformatf("row%0d i_rdata", i),  i_rdata, vecs[i].ex[2] ? c_rd : 256'd0);
            chk($sformatf("row%0d d_rdata", i),  d_rdata, vecs[i].ex[1] ? c_rd : 256'd0);
            if (vecs[i].ex[0]) chk($sformatf("row%0d l2_wdata", i), l2_wdata, c_wd);
            tick();
        end
        rst = 1'b0;
        chk("tie i_grant_cnt", 256'(i_grant_cnt), 256'd3);
        chk("tie d_grant_cnt", 256'(d_grant_cnt), 256'd2);
        chk("tie i_wait_cnt",  256'(i_wait_cnt),  256'd6);
        chk("tie d_wait_cnt",  256'(d_wait_cnt),  256'd6);

        // Long miss on D while I waits
        rst = 1'b1; tick(); rst = 1'b0;
        d_read = 1'b1; d_addr = 32'h4000;
        tick();
        i_read = 1'b1; i_addr = 32'h5000;
        #1;
        chk("miss issue rmask", 256'(l2_rmask), 256'hF);
        chk("miss issue addr",  256'(l2_addr),  256'h4000);
        tick();
        chk("miss wait start", 256'(i_wait_cnt), 256'd1);
        for (int k = 0; k < 20; k++) begin
            #1;
            chk($sformatf("miss%0d masks", k), 256'({l2_rmask, l2_wmask}), 256'd0);
            chk($sformatf("miss%0d resp", k),  256'({i_resp, d_resp}), 256'd0);
            tick();
        end
        l2_resp = 1'b1;
        #1;
        chk("miss d_resp",   256'(d_resp), 256'd1);
        chk("miss i_resp",   256'(i_resp), 256'd0);
        chk("miss i_wait",   256'(i_wait_cnt), 256'd21);
        tick();
        l2_resp = 1'b0; d_read = 1'b0;
        #1;
        chk("miss idle rmask", 256'(l2_rmask), 256'd0);
        tick();
        chk("miss i issue rmask", 256'(l2_rmask), 256'hF);
        chk("miss i issue addr",  256'(l2_addr),  256'h5000);
        chk("miss i grant",       256'(i_grant_cnt), 256'd1);
        chk("miss i wait final",  256'(i_wait_cnt),  256'd22);
        tick();
        l2_resp = 1'b1; i_read = 1'b0;
        #1;
        chk("miss i resp", 256'(i_resp), 256'd1);
        tick();
        l2_resp = 1'b0;

        // Reset in the middle of WAIT, then a fresh read
        i_read = 1'b1; i_addr = 32'h6000;
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("rstwait i_resp", 256'(i_resp), 256'd0);
        tick();
        rst = 1'b0; i_read = 1'b0;
        #1;
        chk("rstwait l2_addr",  256'(l2_addr), 256'd0);
        chk("rstwait l2_wdata", l2_wdata, 256'd0);
        chk("rstwait masks",    256'({l2_rmask, l2_wmask}), 256'd0);
        chk("rstwait resp",     256'({i_resp, d_resp}), 256'd0);
        chk("rstwait counters", 256'({i_grant_cnt, d_grant_cnt, i_wait_cnt, d_wait_cnt}), 256'd0);
        i_read = 1'b1; i_addr = 32'h7000;
        tick();
        chk("fresh rmask", 256'(l2_rmask), 256'hF);
        chk("fresh addr",  256'(l2_addr),  256'h7000);
        chk("fresh grant", 256'(i_grant_cnt), 256'd1);
        tick();
        l2_resp = 1'b1;
        #1;
        chk("fresh i_resp",  256'(i_resp), 256'd1);
        chk("fresh i_rdata", i_rdata, c_rd);
        tick();
        l2_resp = 1'b0; i_read = 1'b0;
        #1;
        chk("fresh idle rmask", 256'(l2_rmask), 256'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
